dcache_responder: RTL

- Responder end of the backend-to-dcache load/store protocol; the backend ex/mem stages are the initiator.
- Direct-mapped, write-through, no-write-allocate, blocking data cache with a flop array.
- Serves cached loads from the array. Refills missing lines by burst read. Forwards every store, and every uncached access, to the memory bus.
- Sits between the backend and the AXI bridge.

---
 rtl/pipeline_types.sv | 41 ++++
 rtl/dcache_data_array.sv | 58 +++++
 rtl/dcache_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_types.sv
// Shared pipeline types: backend-to-dcache request record, dcache FSM states and op codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipeline_types;

  // Widest physical address the request record can carry.
  localparam int DCACHE_ADDR_W = 32;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_LOOKUP,
    DC_MISS,
    DC_REFILL,
    DC_UNC_RD,
    DC_WRITE
  } dcache_state_t;

  localparam logic DCACHE_OP_LOAD  = 1'b0;
  localparam logic DCACHE_OP_STORE = 1'b1;

  typedef struct packed {
    logic                     we;
    logic                     uncached;
    logic [DCACHE_ADDR_W-1:0] paddr;
    logic [3:0]               wstrb;
    logic [31:0]              wdata;
  } dcache_req_t;

  // Byte-masked merge of new data over an old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Flop storage of valid bits, tags and line data for the direct-mapped dcache.
// Latency: combinational read port; writes take effect at the next clock edge.
// Backpressure: none, every write is accepted.
// Ports: read port (rd_index, rd_offset -> rd_valid, rd_tag, rd_word); byte-masked
// word write port (word_*); valid/tag write port (tag_*). Only valid bits are reset.
module dcache_data_array
  import pipeline_types::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 22,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             word_we,
  input  logic [IDX_W-1:0] word_index,
  input  logic [OFF_W-1:0] word_offset,
  input  logic [3:0]       word_strb,
  input  logic [31:0]      word_data,
  input  logic             tag_we,
  input  logic [IDX_W-1:0] tag_index,
  input  logic             tag_valid,
  input  logic [TAG_W-1:0] tag_value
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[tag_index] <= tag_valid;
    end
  end

  // Tags and data need no reset: they are only trusted behind a set valid bit.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[tag_index] <= tag_value;
    if (word_we) begin
      data_q[word_index][word_offset] <=
        merge_bytes(data_q[word_index][word_offset], word_data, word_strb);
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/dcache_responder.sv
// Blocking direct-mapped write-through no-write-allocate dcache between backend and AXI bridge.
// Latency: load hit -> data_ok 1 cycle after addr_ok; misses, uncached and stores wait on the bus.
// Backpressure: one request in flight; addr_ok only in IDLE; rd/wr requests held until rd_rdy/wr_rdy.
// Ports: req_* / addr_ok / data_ok / rdata face the backend; rd_* / ret_* / wr_* face the bus.
// Optional: DCACHE_PERF_CNT_EN adds saturating hit_cnt / miss_cnt outputs for cached loads.
module dcache_responder
  import pipeline_types::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_uncached,
  input  logic [ADDR_W-1:0] req_paddr,
  input  logic [3:0]        req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              rd_req,
  output logic              rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_strb,
  output logic [31:0]       wr_data,
  input  logic              wr_rdy
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  dcache_state_t state, state_n;
  dcache_req_t   req_q;
  logic [OFF_W-1:0] beat_q;
  logic [31:0]      crit_q;      // requested word, if it arrived before the last beat
  logic             crit_vld_q;
  logic             rd_sent_q;   // uncached read handshake done, waiting for the data beat

  logic [ADDR_W-1:0] req_addr;
  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              unused_addr_bits;

  assign req_addr         = req_q.paddr[ADDR_W-1:0];
  assign req_off          = req_addr[OFF_W+1:2];
  assign req_idx          = req_addr[OFF_W+2 +: IDX_W];
  assign req_tag          = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^req_addr[1:0];

  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [31:0]      arr_word;
  logic             word_we;
  logic [OFF_W-1:0] word_off;
  logic [3:0]       word_strb;
  logic [31:0]      word_data;
  logic             tag_we;
  logic             tag_valid;
  logic             hit;

  assign hit = arr_valid && (arr_tag == req_tag);

  dcache_data_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (req_idx),
    .rd_offset   (req_off),
    .rd_valid    (arr_valid),
    .rd_tag      (arr_tag),
    .rd_word     (arr_word),
    .word_we     (word_we),
    .word_index  (req_idx),
    .word_offset (word_off),
    .word_strb   (word_strb),
    .word_data   (word_data),
    .tag_we      (tag_we),
    .tag_index   (req_idx),
    .tag_valid   (tag_valid),
    .tag_value   (req_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= DC_IDLE;
      req_q      <= '0;
      beat_q     <= '0;
      crit_q     <= '0;
      crit_vld_q <= 1'b0;
      rd_sent_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (addr_ok) begin
        req_q <= '{we:       req_we,
                   uncached: req_uncached,
                   paddr:    DCACHE_ADDR_W'(req_paddr),
                   wstrb:    req_wstrb,
                   wdata:    req_wdata};
      end
      case (state)
        DC_LOOKUP: rd_sent_q <= 1'b0;
        DC_MISS: begin
          beat_q     <= '0;
          crit_vld_q <= 1'b0;
        end
        DC_REFILL: begin
          if (ret_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == req_off) begin
              crit_q     <= ret_data;
              crit_vld_q <= 1'b1;
            end
          end
        end
        DC_UNC_RD: if (rd_rdy) rd_sent_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    rd_req    = 1'b0;
    rd_type   = 1'b0;
    rd_addr   = '0;
    wr_req    = 1'b0;
    wr_addr   = '0;
    wr_strb   = '0;
    wr_data   = '0;
    word_we   = 1'b0;
    word_off  = req_off;
    word_strb = '0;
    word_data = '0;
    tag_we    = 1'b0;
    tag_valid = 1'b0;

    case (state)
      DC_IDLE: begin
        addr_ok = req_valid;
        if (req_valid) state_n = DC_LOOKUP;
      end

      DC_LOOKUP: begin
        if (req_q.we == DCACHE_OP_STORE) begin
          // Write-through: update a resident line, never allocate on a miss.
          if (!req_q.uncached && hit) begin
            word_we   = 1'b1;
            word_strb = req_q.wstrb;
            word_data = req_q.wdata;
          end
          state_n = DC_WRITE;
        end else if (req_q.uncached) begin
          state_n = DC_UNC_RD;
        end else if (hit) begin
          data_ok = 1'b1;
          rdata   = arr_word;
          state_n = DC_IDLE;
        end else begin
          state_n = DC_MISS;
        end
      end

      DC_MISS: begin
        rd_req  = 1'b1;
        rd_type = 1'b1;
        rd_addr = {req_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        if (rd_rdy) begin
          // Invalidate the victim so a short burst cannot leave a stale line valid.
          tag_we    = 1'b1;
          tag_valid = 1'b0;
          state_n   = DC_REFILL;
        end
      end

      DC_REFILL: begin
        if (ret_valid) begin
          word_we   = 1'b1;
          word_off  = beat_q;
          word_strb = 4'hF;
          word_data = ret_data;
          if (ret_last) begin
            data_ok = 1'b1;
            if (beat_q == req_off) rdata = ret_data;
            else if (crit_vld_q)   rdata = crit_q;
            if (beat_q == LAST_BEAT) begin
              tag_we    = 1'b1;
              tag_valid = 1'b1;
            end
            state_n = DC_IDLE;
          end
        end
      end

      DC_UNC_RD: begin
        if (!rd_sent_q) begin
          rd_req  = 1'b1;
          rd_addr = req_addr;
        end else if (ret_valid) begin
          data_ok = 1'b1;
          rdata   = ret_data;
          state_n = DC_IDLE;
        end
      end

      DC_WRITE: begin
        wr_req  = 1'b1;
        wr_addr = req_addr;
        wr_strb = req_q.wstrb;
        wr_data = req_q.wdata;
        if (wr_rdy) begin
          data_ok = 1'b1;
          state_n = DC_IDLE;
        end
      end

      default: state_n = DC_IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic cached_load_lookup;
  assign cached_load_lookup = (state == DC_LOOKUP) && (req_q.we == DCACHE_OP_LOAD) &&
                              !req_q.uncached;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cached_load_lookup) begin
      if (hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
      if (!hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule
